pe_array_tile: RTL and testbench

- Output-stationary 2-D MAC tile: ROWS x COLS accumulators, successor to the 1-D shared-weight PE array.
- Streams K beats per job. Each beat carries ROWS activations and COLS weights; every cell does acc[r][c] += act[r]*wet[c].
- An on-block controller sequences the job: auto-clear, K counting, requantize (shift + saturate), and row-by-row drain over a valid/ready handshake.
- Sits between the activation/weight buffers and the output-activation writer.

---
 rtl/pe_tile_pkg.sv | 44 ++++
 rtl/pe_mac_cell.sv | 35 +++
 rtl/pe_array_tile.sv | 151 +++++++++++++++
 tb/tb_pe_array_tile.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_tile_pkg.sv
// Shared types and helpers for the output-stationary PE tile.
// Contents: state enum, activation clamp bounds, and the requant() helper
// (round/shift/saturate). Optional build macro PE_TILE_ROUND_EN switches
// requant() from truncating shift to round-half-up before the shift.
package pe_tile_pkg;

   localparam int unsigned BW_ACT_P  = 8;
   localparam int unsigned BW_ACCU_P = 32;

   localparam int signed ACT_MAX = int'((1 << (BW_ACT_P - 1)) - 1);
   localparam int signed ACT_MIN = -ACT_MAX - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Requantize one accumulator: optional rounding, arithmetic shift, clamp.
   // Work is done in BW_ACCU_P+1 bits so the rounding add cannot overflow.
   function automatic logic signed [BW_ACT_P-1:0] requant(
      input logic signed [BW_ACCU_P-1:0] acc,
      input logic        [7:0]           shift
   );
      logic signed [BW_ACCU_P:0] ext;
      logic signed [BW_ACCU_P:0] shifted;
      logic        [7:0]         sa;
      ext = {acc[BW_ACCU_P-1], acc};
`ifdef PE_TILE_ROUND_EN
      if (shift != 8'd0 && 32'(shift) <= BW_ACCU_P)
         ext = ext + ((BW_ACCU_P + 1)'(1) << (shift - 8'd1));
`endif
      // Any shift past the accumulator width just leaves the sign fill.
      sa      = (32'(shift) > BW_ACCU_P) ? 8'(BW_ACCU_P) : shift;
      shifted = ext >>> sa;
      if (shifted > $signed((BW_ACCU_P + 1)'(ACT_MAX)))
         requant = BW_ACT_P'(ACT_MAX);
      else if (shifted < $signed((BW_ACCU_P + 1)'(ACT_MIN)))
         requant = BW_ACT_P'(ACT_MIN);
      else
         requant = BW_ACT_P'(shifted);
   endfunction

endpackage

// File: rtl/pe_mac_cell.sv
// Single multiply-accumulate cell of the PE tile.
// Ports: clk, reset_n (async, active-low); en = accept a beat;
// first = overwrite instead of accumulate; act/wet = signed operands;
// acc = registered signed accumulator (wraps modulo 2^BW_ACCU).
module pe_mac_cell
   import pe_tile_pkg::*;
#(
   parameter int unsigned BW_ACT  = BW_ACT_P,
   parameter int unsigned BW_WET  = 8,
   parameter int unsigned BW_ACCU = BW_ACCU_P
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      en,
   input  logic                      first,
   input  logic signed [BW_ACT-1:0]  act,
   input  logic signed [BW_WET-1:0]  wet,
   output logic signed [BW_ACCU-1:0] acc
);

   logic signed [BW_ACT+BW_WET-1:0] prod;
   logic signed [BW_ACCU-1:0]       prod_ext;

   assign prod     = act * wet;
   assign prod_ext = BW_ACCU'(prod);

   // First beat of a job overwrites, so no separate clear cycle is needed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         acc <= '0;
      else if (en)
         acc <= first ? prod_ext : acc + prod_ext;
   end

endmodule

// File: rtl/pe_array_tile.sv
// Output-stationary ROWS x COLS MAC tile with on-block job controller.
// Ports: clk, reset_n (async, active-low); start/cfg_k_len/cfg_shift job
// setup; in_valid/in_ready/in_act/in_wet input beats; out_valid/out_ready/
// out_data/out_row requantized row drain; busy (ACCUM or DRAIN); done pulse.
// Build macro PE_TILE_ROUND_EN enables round-half-up in requantization.
module pe_array_tile
   import pe_tile_pkg::*;
#(
   parameter int unsigned ROWS    = 4,
   parameter int unsigned COLS    = 4,
   parameter int unsigned BW_ACT  = BW_ACT_P,
   parameter int unsigned BW_WET  = 8,
   parameter int unsigned BW_ACCU = BW_ACCU_P,
   parameter int unsigned BW_K    = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start,
   input  logic [BW_K-1:0]                 cfg_k_len,
   input  logic [7:0]                      cfg_shift,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ROWS*BW_ACT-1:0]          in_act,
   input  logic [COLS*BW_WET-1:0]          in_wet,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [COLS*BW_ACT-1:0]          out_data,
   output logic [$clog2(ROWS)-1:0]         out_row,
   output logic                            busy,
   output logic                            done
);

   localparam int unsigned ROW_W = $clog2(ROWS);

   state_t            state, next_state;
   logic [BW_K-1:0]   k_cnt, k_cnt_d;
   logic [BW_K-1:0]   k_len, k_len_d;
   logic [7:0]        shift, shift_d;
   logic [ROW_W-1:0]  row_d;
   logic              done_d;
   logic              acc_en;
   logic              acc_first;
   logic              beat;
   logic              take;

   logic signed [BW_ACCU-1:0] acc [ROWS][COLS];

   // MAC grid: every cell sees its row activation and its column weight.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         pe_mac_cell #(
            .BW_ACT  (BW_ACT),
            .BW_WET  (BW_WET),
            .BW_ACCU (BW_ACCU)
         ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (acc_en),
            .first   (acc_first),
            .act     (in_act[r*BW_ACT +: BW_ACT]),
            .wet     (in_wet[c*BW_WET +: BW_WET]),
            .acc     (acc[r][c])
         );
      end
   end

   assign beat = in_valid && in_ready;
   assign take = out_valid && out_ready;

   // State and control registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         k_cnt     <= '0;
         k_len     <= '0;
         shift     <= '0;
         out_row   <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= next_state;
         k_cnt     <= k_cnt_d;
         k_len     <= k_len_d;
         shift     <= shift_d;
         out_row   <= row_d;
         in_ready  <= (next_state == ACCUM);
         out_valid <= (next_state == DRAIN);
         busy      <= (next_state != IDLE);
         done      <= done_d;
      end
   end

   // Next-state and control decode.
   always_comb begin
      next_state = state;
      k_cnt_d    = k_cnt;
      k_len_d    = k_len;
      shift_d    = shift;
      row_d      = out_row;
      done_d     = 1'b0;
      acc_en     = 1'b0;
      acc_first  = 1'b0;
      case (state)
         IDLE: begin
            if (start && cfg_k_len != '0) begin
               next_state = ACCUM;
               k_len_d    = cfg_k_len;
               shift_d    = cfg_shift;
               k_cnt_d    = '0;
               row_d      = '0;
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_en    = 1'b1;
               acc_first = (k_cnt == '0);
               if (k_cnt == k_len - BW_K'(1)) begin
                  next_state = DRAIN;
                  k_cnt_d    = '0;
               end else begin
                  k_cnt_d = k_cnt + BW_K'(1);
               end
            end
         end
         DRAIN: begin
            if (take) begin
               if (out_row == ROW_W'(ROWS - 1)) begin
                  next_state = IDLE;
                  done_d     = 1'b1;
                  row_d      = '0;
               end else begin
                  row_d = out_row + ROW_W'(1);
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Drain mux: requantize the presented row; zero when no row is offered.
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         for (int c = 0; c < COLS; c++)
            out_data[c*BW_ACT +: BW_ACT] = requant(acc[out_row][c], shift);
      end
   end

endmodule

// File: tb/tb_pe_array_tile.sv
// Self-checking bench for pe_array_tile: directed corner jobs plus random
// jobs, checked against an arithmetic reference of the tile's job result.
module tb_pe_array_tile;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int BA   = 8;
   localparam int BWW  = 8;
   localparam int BK   = 16;
   localparam int MAXK = 64;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 start;
   logic [BK-1:0]        cfg_k_len;
   logic [7:0]           cfg_shift;
   logic                 in_valid;
   logic                 in_ready;
   logic [ROWS*BA-1:0]   in_act;
   logic [COLS*BWW-1:0]  in_wet;
   logic                 out_valid;
   logic                 out_ready;
   logic [COLS*BA-1:0]   out_data;
   logic [1:0]           out_row;
   logic                 busy;
   logic                 done;

   int checks = 0;
   int errors = 0;

   int act_m [MAXK][ROWS];
   int wet_m [MAXK][COLS];

   always #5 clk = ~clk;

   pe_array_tile dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .cfg_k_len (cfg_k_len),
      .cfg_shift (cfg_shift),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_act    (in_act),
      .in_wet    (in_wet),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference requantization from plain integer arithmetic.
   function automatic longint ref_requant(input longint a, input int s);
      longint v;
      v = a;
`ifdef PE_TILE_ROUND_EN
      if (s > 0 && s <= 32) v = v + (longint'(1) << (s - 1));
`endif
      if (s > 63) s = 63;
      v = v >>> s;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return v;
   endfunction

   task automatic fill_const(input int k, input int a, input int w);
      for (int b = 0; b < k; b++) begin
         for (int r = 0; r < ROWS; r++) act_m[b][r] = a;
         for (int c = 0; c < COLS; c++) wet_m[b][c] = w;
      end
   endtask

   task automatic fill_rand(input int k);
      for (int b = 0; b < k; b++) begin
         for (int r = 0; r < ROWS; r++) act_m[b][r] = int'($urandom_range(255)) - 128;
         for (int c = 0; c < COLS; c++) wet_m[b][c] = int'($urandom_range(255)) - 128;
      end
   endtask

   task automatic drive_beat(input int b);
      for (int r = 0; r < ROWS; r++) in_act[r*BA +: BA] = 8'(act_m[b][r]);
      for (int c = 0; c < COLS; c++) in_wet[c*BWW +: BWW] = 8'(wet_m[b][c]);
   endtask

   // One complete job: start, K beats (vprob % valid), drain with optional stall.
   task automatic run_job(input int k, input int sh, input int vprob,
                          input int stall_row, input int stall_n, input bit restart);
      longint exp_acc [ROWS][COLS];
      longint sum;
      int     beat, guard, row, stalled;
      bit     acc_now, go;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            sum = 0;
            for (int b = 0; b < k; b++) sum += longint'(act_m[b][r]) * longint'(wet_m[b][c]);
            exp_acc[r][c] = longint'(int'(sum));
         end

      @(negedge clk);
      start = 1'b1; cfg_k_len = BK'(k); cfg_shift = 8'(sh);
      @(negedge clk);
      start = 1'b0;
      check("busy_accum", longint'(busy), 1);
      check("in_ready_accum", longint'(in_ready), 1);

      beat = 0; guard = 0;
      while (beat < k && guard < 2000) begin
         guard++;
         if (restart && guard == 1) begin
            start = 1'b1; cfg_shift = 8'(sh + 3); cfg_k_len = BK'(k + 1);
         end else begin
            start = 1'b0;
         end
         in_valid = ($urandom_range(99) < 32'(vprob));
         drive_beat(beat);
         acc_now = in_valid && in_ready;
         @(negedge clk);
         if (acc_now) beat++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (beat < k) check("accum_timeout", beat, k);

      check("in_ready_drain", longint'(in_ready), 0);
      check("out_valid_first", longint'(out_valid), 1);
      row = 0; guard = 0; stalled = 0;
      while (row < ROWS && guard < 100) begin
         guard++;
         check($sformatf("out_row[%0d]", row), longint'(out_row), row);
         for (int c = 0; c < COLS; c++)
            check($sformatf("out_data[%0d][%0d]", row, c),
                  longint'($signed(out_data[c*BA +: BA])),
                  ref_requant(exp_acc[row][c], sh));
         if (row == stall_row && stalled < stall_n) begin
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = 1'b1;
         end
         go = out_ready && out_valid;
         @(negedge clk);
         if (go) row++;
      end
      out_ready = 1'b0;
      if (row < ROWS) check("drain_timeout", row, ROWS);
      check("done_pulse", longint'(done), 1);
      check("busy_after", longint'(busy), 0);
      check("out_valid_after", longint'(out_valid), 0);
      @(negedge clk);
      check("done_single", longint'(done), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  longint'(in_ready), 0);
      check({tag, "_out_valid"}, longint'(out_valid), 0);
      check({tag, "_busy"},      longint'(busy), 0);
      check({tag, "_done"},      longint'(done), 0);
      check({tag, "_out_data"},  longint'(out_data), 0);
      check({tag, "_out_row"},   longint'(out_row), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; cfg_k_len = '0; cfg_shift = '0;
      in_valid = 1'b0; in_act = '0; in_wet = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Basic job.
      fill_const(3, 1, 1);     run_job(3, 0, 100, -1, 0, 0);
      // Positive and negative saturation.
      fill_const(8, 127, 127); run_job(8, 0, 100, -1, 0, 0);
      fill_const(8, -128, 127); run_job(8, 0, 100, -1, 0, 0);
      // Shift.
      fill_const(4, 16, 16);   run_job(4, 8, 100, -1, 0, 0);
      // Rounding boundaries.
      fill_const(1, 3, 1);     run_job(1, 1, 100, -1, 0, 0);
      fill_const(1, -3, 1);    run_job(1, 1, 100, -1, 0, 0);
      // Oversized shifts give the sign fill.
      fill_const(1, -3, 1);    run_job(1, 40, 100, -1, 0, 0);
      fill_const(1, 3, 1);     run_job(1, 32, 100, -1, 0, 0);
      // Backpressure on row 1 for 5 cycles.
      fill_rand(6);            run_job(6, 4, 100, 1, 5, 0);
      // Random jobs with 50% input valid and occasional stalls.
      for (int j = 0; j < 6; j++) begin
         int k;
         k = int'($urandom_range(20, 1));
         fill_rand(k);
         run_job(k, int'($urandom_range(14)), 50, int'($urandom_range(3)),
                 int'($urandom_range(4)), 0);
      end
      // Start during ACCUM with new cfg is ignored.
      fill_rand(5);            run_job(5, 6, 100, -1, 0, 1);

      // Start with k_len==0 is ignored.
      @(negedge clk);
      start = 1'b1; cfg_k_len = '0; cfg_shift = 8'd2;
      @(negedge clk);
      start = 1'b0;
      check("zero_k_in_ready", longint'(in_ready), 0);
      check("zero_k_busy", longint'(busy), 0);
      @(negedge clk);
      check("zero_k_in_ready2", longint'(in_ready), 0);

      // Reset mid-job aborts without output or done.
      fill_const(5, 9, 9);
      start = 1'b1; cfg_k_len = BK'(5); cfg_shift = '0;
      @(negedge clk);
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1; drive_beat(b);
         @(negedge clk);
      end
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      check_all_zero("abort");
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", longint'(done), 0);
         check("abort_no_valid", longint'(out_valid), 0);
      end
      fill_const(1, 2, 3);     run_job(1, 0, 100, -1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
